// File: rtl/blackjack_table_if.sv
// Agent/card-source bundle for the blackjack_table episode engine.
// The table uses the slave modport; the agent/card source side uses master.
interface blackjack_table_if #(
  parameter int CARD_W = 4,
  parameter int SUM_W  = 5
);
  logic [CARD_W-1:0] i_card;
  logic              o_card_req;
  logic              i_start;
  logic              i_act_valid;
  logic              i_act;
  logic              o_act_ready;
  logic              o_obs_valid;
  logic [SUM_W-1:0]  o_player_sum;
  logic [CARD_W-1:0] o_dealer_show;
  logic              o_usable_ace;
  logic              o_done;
  logic [1:0]        o_reward;

  modport master (
    output i_card, i_start, i_act_valid, i_act,
    input  o_card_req, o_act_ready, o_obs_valid, o_player_sum,
           o_dealer_show, o_usable_ace, o_done, o_reward
  );

  modport slave (
    input  i_card, i_start, i_act_valid, i_act,
    output o_card_req, o_act_ready, o_obs_valid, o_player_sum,
           o_dealer_show, o_usable_ace, o_done, o_reward
  );
endinterface

// File: rtl/blackjack_table.sv
// Blackjack episode engine: deals hands, takes hit/stick, plays the dealer, scores.
// Optional macro HIT_SOFT17_EN makes the dealer hit a soft 17.
module blackjack_table #(
  parameter int CARD_W = 4,
  parameter int SUM_W  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  blackjack_table_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEAL   = 3'd1;
  localparam logic [2:0] S_PLAYER = 3'd2;
  localparam logic [2:0] S_PHIT   = 3'd3;
  localparam logic [2:0] S_DEALER = 3'd4;
  localparam logic [2:0] S_SCORE  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]        state;
  logic [1:0]        deal_cnt;
  logic [SUM_W-1:0]  player_hard;
  logic [SUM_W-1:0]  dealer_hard;
  logic              player_ace;
  logic              dealer_ace;
  logic [CARD_W-1:0] dealer_show;
  logic [1:0]        reward;

  logic [SUM_W-1:0]  card_val;
  logic              card_is_ace;
  logic              player_usable;
  logic              dealer_usable;
  logic [SUM_W-1:0]  player_eff;
  logic [SUM_W-1:0]  dealer_eff;
  logic [SUM_W-1:0]  player_next;
  logic [SUM_W-1:0]  dealer_next;
  logic              dealer_draw;
  logic              card_req;

  // Out-of-range card values from the source are clamped into 1..10
  always_comb begin
    card_val = SUM_W'(bus.i_card);
    if (bus.i_card == '0)
      card_val = SUM_W'(1);
    else if (bus.i_card > CARD_W'(10))
      card_val = SUM_W'(10);
  end

  assign card_is_ace   = (card_val == SUM_W'(1));
  assign player_usable = player_ace && (player_hard <= SUM_W'(11));
  assign dealer_usable = dealer_ace && (dealer_hard <= SUM_W'(11));
  assign player_eff    = player_usable ? player_hard + SUM_W'(10) : player_hard;
  assign dealer_eff    = dealer_usable ? dealer_hard + SUM_W'(10) : dealer_hard;
  assign player_next   = player_hard + card_val;
  assign dealer_next   = dealer_hard + card_val;

`ifdef HIT_SOFT17_EN
  assign dealer_draw = (dealer_eff < SUM_W'(17)) ||
                       ((dealer_eff == SUM_W'(17)) && dealer_usable);
`else
  assign dealer_draw = (dealer_eff < SUM_W'(17));
`endif

  // Purely from state so reset drops the request without waiting for an edge
  assign card_req = (state == S_DEAL) || (state == S_PHIT) ||
                    ((state == S_DEALER) && dealer_draw);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      deal_cnt    <= 2'd0;
      player_hard <= '0;
      dealer_hard <= '0;
      player_ace  <= 1'b0;
      dealer_ace  <= 1'b0;
      dealer_show <= '0;
      reward      <= 2'b00;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            state       <= S_DEAL;
            deal_cnt    <= 2'd0;
            player_hard <= '0;
            dealer_hard <= '0;
            player_ace  <= 1'b0;
            dealer_ace  <= 1'b0;
            dealer_show <= '0;
            reward      <= 2'b00;
          end
        end
        // Deal order: player, dealer face-up, player, dealer hidden
        S_DEAL: begin
          if (deal_cnt[0] == 1'b0) begin
            player_hard <= player_next;
            player_ace  <= player_ace | card_is_ace;
          end else begin
            dealer_hard <= dealer_next;
            dealer_ace  <= dealer_ace | card_is_ace;
          end
          if (deal_cnt == 2'd1)
            dealer_show <= CARD_W'(card_val);
          deal_cnt <= deal_cnt + 2'd1;
          if (deal_cnt == 2'd3)
            state <= S_PLAYER;
        end
        S_PLAYER: begin
          if (bus.i_act_valid)
            state <= bus.i_act ? S_PHIT : S_DEALER;
        end
        S_PHIT: begin
          player_hard <= player_next;
          player_ace  <= player_ace | card_is_ace;
          if (player_next > SUM_W'(21)) begin
            reward <= 2'b11;
            state  <= S_DONE;
          end else begin
            state <= S_PLAYER;
          end
        end
        S_DEALER: begin
          if (dealer_draw) begin
            dealer_hard <= dealer_next;
            dealer_ace  <= dealer_ace | card_is_ace;
          end else begin
            state <= S_SCORE;
          end
        end
        S_SCORE: begin
          if ((dealer_eff > SUM_W'(21)) || (player_eff > dealer_eff))
            reward <= 2'b01;
          else if (player_eff == dealer_eff)
            reward <= 2'b00;
          else
            reward <= 2'b11;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_card_req    = card_req;
  assign bus.o_act_ready   = (state == S_PLAYER);
  assign bus.o_obs_valid   = (state == S_PLAYER) || (state == S_DONE);
  assign bus.o_player_sum  = player_eff;
  assign bus.o_dealer_show = dealer_show;
  assign bus.o_usable_ace  = player_usable;
  assign bus.o_done        = (state == S_DONE);
  assign bus.o_reward      = reward;

endmodule

// File: tb/tb_blackjack_table.sv
// Directed bench for blackjack_table: scripted decks, hand-computed outcomes.
// A small card-source model advances the deck on every o_card_req edge.
module tb_blackjack_table;

  logic i_clk = 1'b0;
  logic i_rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   idx = 0;
  int   base = 0;
  logic [3:0] deck [0:255];

  blackjack_table_if #(.CARD_W(4), .SUM_W(5)) bus ();

  blackjack_table #(.CARD_W(4), .SUM_W(5)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  // Card source: presents deck[idx] and advances once per consumed card
  assign bus.i_card = deck[idx % 256];
  always @(posedge i_clk) begin
    if (bus.o_card_req)
      idx <= idx + 1;
  end

  task automatic applyStimulus(input logic start, input logic act_valid, input logic act);
    bus.i_start     = start;
    bus.i_act_valid = act_valid;
    bus.i_act       = act;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic loadCards(input logic [3:0] c0, c1, c2, c3, c4, c5);
    deck[(idx + 0) % 256] = c0;
    deck[(idx + 1) % 256] = c1;
    deck[(idx + 2) % 256] = c2;
    deck[(idx + 3) % 256] = c3;
    deck[(idx + 4) % 256] = c4;
    deck[(idx + 5) % 256] = c5;
    base = idx;
  endtask

  task automatic startEpisode();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("deal_obs_low", 8'(bus.o_obs_valid), 8'd0);
    checkOutput("start_clears_done", 8'(bus.o_done), 8'd0);
    checkOutput("start_clears_reward", 8'(bus.o_reward), 8'd0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("deal_last_obs_low", 8'(bus.o_obs_valid), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("player_obs_valid", 8'(bus.o_obs_valid), 8'd1);
    checkOutput("player_act_ready", 8'(bus.o_act_ready), 8'd1);
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget && !bus.o_done; i++)
      applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("done_within_budget", 8'(bus.o_done), 8'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) deck[i] = 4'd10;
    i_rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_act_valid = 1'b0;
    bus.i_act = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst_obs_valid", 8'(bus.o_obs_valid), 8'd0);
    checkOutput("rst_card_req", 8'(bus.o_card_req), 8'd0);
    checkOutput("rst_done", 8'(bus.o_done), 8'd0);
    checkOutput("rst_player_sum", 8'(bus.o_player_sum), 8'd0);
    i_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] stick loss");
    loadCards(4'd10, 4'd5, 4'd7, 4'd6, 4'd9, 4'd10);
    startEpisode();
    checkOutput("loss_player_sum", 8'(bus.o_player_sum), 8'd17);
    checkOutput("loss_dealer_show", 8'(bus.o_dealer_show), 8'd5);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDone(10);
    checkOutput("loss_reward", 8'(bus.o_reward), 8'h3);
    checkOutput("loss_pulses", 8'(idx - base), 8'd5);
    checkOutput("loss_final_sum", 8'(bus.o_player_sum), 8'd17);

    $display("[TB] hit bust, started in the cycle done rose");
    loadCards(4'd10, 4'd2, 4'd6, 4'd3, 4'd10, 4'd10);
    startEpisode();
    checkOutput("bust_player_sum", 8'(bus.o_player_sum), 8'd16);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("phit_not_ready", 8'(bus.o_act_ready), 8'd0);
    checkOutput("phit_not_done", 8'(bus.o_done), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bust_done_m2", 8'(bus.o_done), 8'd1);
    checkOutput("bust_reward", 8'(bus.o_reward), 8'h3);
    checkOutput("bust_hard_sum", 8'(bus.o_player_sum), 8'd26);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("bust_no_dealer_draw", 8'(idx - base), 8'd5);
    checkOutput("bust_reward_held", 8'(bus.o_reward), 8'h3);

    $display("[TB] usable ace");
    loadCards(4'd1, 4'd4, 4'd6, 4'd5, 4'd10, 4'd10);
    startEpisode();
    checkOutput("ace_soft_sum", 8'(bus.o_player_sum), 8'd17);
    checkOutput("ace_usable", 8'(bus.o_usable_ace), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ace_hard_sum", 8'(bus.o_player_sum), 8'd17);
    checkOutput("ace_not_usable", 8'(bus.o_usable_ace), 8'd0);
    checkOutput("ace_not_done", 8'(bus.o_done), 8'd0);
    checkOutput("ace_back_player", 8'(bus.o_act_ready), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDone(10);
    checkOutput("ace_reward", 8'(bus.o_reward), 8'h3);

    $display("[TB] soft 17");
    loadCards(4'd10, 4'd1, 4'd8, 4'd6, 4'd3, 4'd10);
    startEpisode();
    checkOutput("s17_player_sum", 8'(bus.o_player_sum), 8'd18);
    checkOutput("s17_dealer_show", 8'(bus.o_dealer_show), 8'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDone(10);
`ifdef HIT_SOFT17_EN
    checkOutput("s17_reward", 8'(bus.o_reward), 8'h3);
    checkOutput("s17_pulses", 8'(idx - base), 8'd5);
`else
    checkOutput("s17_reward", 8'(bus.o_reward), 8'h1);
    checkOutput("s17_pulses", 8'(idx - base), 8'd4);
`endif

    $display("[TB] dealer bust with clamped card");
    loadCards(4'd13, 4'd6, 4'd2, 4'd10, 4'd8, 4'd10);
    startEpisode();
    checkOutput("dbust_player_sum", 8'(bus.o_player_sum), 8'd12);
    checkOutput("dbust_dealer_show", 8'(bus.o_dealer_show), 8'd6);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitDone(10);
    checkOutput("dbust_reward", 8'(bus.o_reward), 8'h1);
    checkOutput("dbust_pulses", 8'(idx - base), 8'd5);

    $display("[TB] ignored start, reset in dealer phase, ignored action");
    loadCards(4'd10, 4'd0, 4'd7, 4'd5, 4'd3, 4'd10);
    startEpisode();
    checkOutput("zero_card_show", 8'(bus.o_dealer_show), 8'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_ignored_ready", 8'(bus.o_act_ready), 8'd1);
    checkOutput("start_ignored_pulses", 8'(idx - base), 8'd4);
    checkOutput("start_ignored_sum", 8'(bus.o_player_sum), 8'd17);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dealer_draw_req", 8'(bus.o_card_req), 8'd1);
    i_rst = 1'b1;
    #1;
    checkOutput("arst_card_req", 8'(bus.o_card_req), 8'd0);
    checkOutput("arst_obs_valid", 8'(bus.o_obs_valid), 8'd0);
    checkOutput("arst_player_sum", 8'(bus.o_player_sum), 8'd0);
    checkOutput("arst_dealer_show", 8'(bus.o_dealer_show), 8'd0);
    checkOutput("arst_usable_ace", 8'(bus.o_usable_ace), 8'd0);
    checkOutput("arst_done", 8'(bus.o_done), 8'd0);
    checkOutput("arst_reward", 8'(bus.o_reward), 8'd0);
    checkOutput("arst_act_ready", 8'(bus.o_act_ready), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    checkOutput("arst_no_extra_card", 8'(idx - base), 8'd4);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("idle_act_no_card", 8'(idx - base), 8'd4);
    checkOutput("idle_act_obs_low", 8'(bus.o_obs_valid), 8'd0);
    checkOutput("idle_act_not_ready", 8'(bus.o_act_ready), 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/blackjack_table.md
# blackjack_table

Episode engine for the BlackJack environment. It consumes card values from the upstream random card source (the LFSR stage, which outputs 1..10) and deals player and dealer hands. It accepts hit/stick actions from the agent, runs the fixed dealer policy, and reports observation, episode-done and reward to the agent interface. Its `o_card_req` drives the card source's enable input, so the source advances exactly once per consumed card.

## Interface
- `CARD_W`, default 4: width of the card input.
- `SUM_W`, default 5: width of the hand sums. The hard sum never exceeds 31, so 5 bits suffice.
- `i_clk` in 1: the single clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_card` in `CARD_W`: current card from the card source, valid every cycle.
- `o_card_req` out 1: high in every cycle where `i_card` is consumed; connects to the card source enable.
- `i_start` in 1: level pulse that starts a new episode.
- `i_act_valid` in 1: agent action valid.
- `i_act` in 1: action, 1 = hit, 0 = stick.
- `o_act_ready` out 1: the block can accept an action.
- `o_obs_valid` out 1: the observation outputs are stable and meaningful.
- `o_player_sum` out `SUM_W`: player effective sum.
- `o_dealer_show` out `CARD_W`: the dealer's face-up card.
- `o_usable_ace` out 1: the player holds an ace counted as 11.
- `o_done` out 1: the episode has finished.
- `o_reward` out 2: signed reward; +1 = 2'b01, 0 = 2'b00, -1 = 2'b11.

## Operation
- **States:** IDLE, DEAL, PLAYER, PHIT, DEALER, SCORE, DONE.
- **Card sanitising:** `i_card` of 0 counts as 1; any value above 10 counts as 10. An ace is value 1.
- **Hand registers:** each hand keeps a hard sum and a has_ace flag.
  - The ace is usable when has_ace is set and hard + 10 ≤ 21.
  - Effective sum = hard + (usable ? 10 : 0).
- **IDLE / DONE:** `i_start` moves to DEAL and clears both hands, `o_done` and `o_reward`. `i_start` is ignored in every other state.
- **DEAL:** takes 4 cycles and consumes one card per cycle in the order player, dealer (shown), player, dealer (hidden). Then goes to PLAYER.
- **PLAYER:** `o_act_ready` = `o_obs_valid` = 1. An action is accepted when `i_act_valid` and `o_act_ready` are both high.
  - Hit goes to PHIT.
  - Stick goes to DEALER.
  - An initial player 21 is not special; the agent still acts.
- **PHIT:** consumes one card into the player hand.
  - If the player hard sum is above 21: reward -1, go to DONE.
  - Otherwise return to PLAYER.
- **DEALER:** each cycle evaluates the dealer effective sum.
  - If it is below 17, or the soft-17 rule applies (see Configuration), consume one card and stay.
  - Otherwise go to SCORE.
- **SCORE:** sets the reward, then goes to DONE.
  - Dealer effective sum above 21: +1.
  - Player sum above dealer sum: +1.
  - Sums equal: 0.
  - Player sum below dealer sum: -1.
- **DONE:** `o_done` = 1 and `o_reward` holds until the next `i_start`. `o_obs_valid` = 1 and the observation shows the final player hand.
- `i_act_valid` outside PLAYER is ignored and never consumes a card.

## Timing
- **Reset:** all outputs are 0, the state is IDLE, and both hands are cleared. Reset asserted mid-episode aborts it immediately; `o_card_req` drops asynchronously, so no extra card is consumed.
- **Card handshake:** `o_card_req` is combinational from the state. The consuming register captures `i_card` on the same edge that advances the card source.
- **Start latency:** `i_start` sampled at edge N gives DEAL on cycles N+1..N+4, and PLAYER with `o_obs_valid` = 1 from cycle N+5.
- **Hit latency:** an action accepted at edge M gives PHIT in cycle M+1. From M+2 the state is either PLAYER (new observation) or DONE with reward -1.
- **Stick latency:** DEALER lasts k+1 cycles for k dealer draws, then SCORE takes 1 cycle, then DONE.
- **Back-to-back:** asserting `i_start` in the same cycle `o_done` rises is honoured on the following edge.
- **Widths:** sums are unsigned `SUM_W`. No overflow is possible: the player maximum is 21 + 10 and the dealer maximum is 16 + 10.

## Configuration
- `HIT_SOFT17_EN`:
  - Defined: the dealer also draws when its effective sum is exactly 17 with a usable ace.
  - Undefined: the dealer stands on every 17.

## Test plan
- **Stick loss:** cards 10,5,7,6 then 9; stick → player 17, dealer show 5, dealer draws once to 20; `o_reward` = 2'b11, 5 `o_card_req` pulses.
- **Hit bust:** cards 10,2,6,3; hit with card 10 → `o_player_sum` 26 internal hard, `o_done` at M+2, reward -1, no dealer draws.
- **Usable ace:** cards 1,4,6,5 → sum 17 with `o_usable_ace` = 1; hit with 10 → sum 17 with `o_usable_ace` = 0; back in PLAYER, not done.
- **Soft 17:** cards 10,1,8,6, stick, next card 3.
  - Without the macro: dealer stands on 17, reward +1.
  - With `HIT_SOFT17_EN`: dealer draws the 3 to reach 20, reward -1.
- **Dealer bust:** cards 10,6,2,10, stick, next 8 → player 12, dealer 24; reward +1.
- **Reset and ignored inputs:** `i_rst` during DEALER → all outputs 0 and no `o_card_req`. `i_start` held during PLAYER is ignored. `i_act_valid` held in IDLE consumes no card.
